// File: rtl/fft_pease_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fft_pease_twiddle_sequencer
// Brief  : Writable sine table streaming per-stage Pease FFT twiddles,
//          LANES per beat, over a val/rdy handshake.
// Rev    : 1.0
// ============================================================================
module fft_pease_twiddle_sequencer #(
    parameter int BIT_WIDTH  = 16,
    parameter int DECIMAL_PT = 8,
    parameter int SIZE_FFT   = 32,
    parameter int LANES      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 tbl_we,
    input  logic [$clog2(SIZE_FFT)-1:0]          tbl_addr,
    input  logic [BIT_WIDTH-1:0]                 tbl_data,
    input  logic                                 start,
    input  logic                                 inverse,
    output logic                                 busy,
    output logic                                 tw_val,
    input  logic                                 tw_rdy,
    output logic [LANES*BIT_WIDTH-1:0]           tw_real,
    output logic [LANES*BIT_WIDTH-1:0]           tw_imag,
    output logic [$clog2($clog2(SIZE_FFT)):0]    tw_stage,
    output logic                                 tw_last_stage,
    output logic                                 tw_last
);

    localparam int c_AW = $clog2(SIZE_FFT);
    localparam int c_L  = c_AW;
    localparam int c_B  = SIZE_FFT / (2 * LANES);
    localparam int c_SW = $clog2(c_L) + 1;
    localparam int c_BW = (c_B > 1) ? $clog2(c_B) : 1;
    localparam logic [BIT_WIDTH-1:0] c_ONE = BIT_WIDTH'(1) << DECIMAL_PT;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t r_state, w_state_n;

    logic [BIT_WIDTH-1:0]       r_tbl [SIZE_FFT];
    logic [c_SW-1:0]            r_stage, w_nstage;
    logic [c_BW-1:0]            r_beat, w_nbeat;
    logic                       r_val, r_last_stage, r_last, r_inv;
    logic [LANES*BIT_WIDTH-1:0] r_real, r_imag, w_real_n, w_imag_n;
    logic                       w_fire, w_load, w_inv, w_last_stage_n, w_last_n;
    int                         w_sh, w_bidx;
    logic [c_AW-1:0]            w_tidx;
    logic [BIT_WIDTH-1:0]       w_sin;

    assign busy          = (r_state == S_STREAM);
    assign tw_val        = r_val;
    assign tw_real       = r_real;
    assign tw_imag       = r_imag;
    assign tw_stage      = r_stage;
    assign tw_last_stage = r_last_stage;
    assign tw_last       = r_last;

    assign w_fire = r_val & tw_rdy;
    assign w_load = ((r_state == S_IDLE) & start) | (w_fire & ~r_last);
    assign w_inv  = (r_state == S_IDLE) ? inverse : r_inv;

    // Table is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (tbl_we && (r_state == S_IDLE)) begin
            r_tbl[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:   if (start)            w_state_n = S_STREAM;
            S_STREAM: if (w_fire && r_last) w_state_n = S_IDLE;
            default:                        w_state_n = S_IDLE;
        endcase
    end

    // Index of the beat about to be loaded into the output registers.
    always_comb begin
        w_nstage = r_stage;
        w_nbeat  = r_beat;
        if (r_state == S_IDLE) begin
            w_nstage = '0;
            w_nbeat  = '0;
        end else if (r_beat == c_BW'(c_B - 1)) begin
            w_nstage = r_stage + c_SW'(1);
            w_nbeat  = '0;
        end else begin
            w_nbeat  = r_beat + c_BW'(1);
        end
        w_last_stage_n = (w_nbeat == c_BW'(c_B - 1));
        w_last_n       = w_last_stage_n && (w_nstage == c_SW'(c_L - 1));
    end

    always_comb begin
        w_real_n = '0;
        w_imag_n = '0;
        w_bidx   = 0;
        w_tidx   = '0;
        w_sin    = '0;
        w_sh     = (int'(w_nstage) >= c_L) ? 0 : (c_L - 1 - int'(w_nstage));
        for (int k = 0; k < LANES; k++) begin
            w_bidx = (int'(w_nbeat) * LANES + k) >> w_sh;
            w_tidx = c_AW'(w_bidx << w_sh);
            if (w_nstage == '0) begin
                w_real_n[k*BIT_WIDTH +: BIT_WIDTH] = c_ONE;
            end else begin
                w_real_n[k*BIT_WIDTH +: BIT_WIDTH] = r_tbl[w_tidx + c_AW'(SIZE_FFT / 4)];
                w_sin = r_tbl[w_tidx + c_AW'(SIZE_FFT / 2)];
                w_imag_n[k*BIT_WIDTH +: BIT_WIDTH] = w_inv ? (-w_sin) : w_sin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val        <= 1'b0;
            r_stage      <= '0;
            r_beat       <= '0;
            r_real       <= '0;
            r_imag       <= '0;
            r_last_stage <= 1'b0;
            r_last       <= 1'b0;
            r_inv        <= 1'b0;
        end else if (w_load) begin
            r_val        <= 1'b1;
            r_stage      <= w_nstage;
            r_beat       <= w_nbeat;
            r_real       <= w_real_n;
            r_imag       <= w_imag_n;
            r_last_stage <= w_last_stage_n;
            r_last       <= w_last_n;
            if (r_state == S_IDLE) r_inv <= inverse;
        end else if (w_fire) begin
            r_val        <= 1'b0;
            r_stage      <= '0;
            r_beat       <= '0;
            r_real       <= '0;
            r_imag       <= '0;
            r_last_stage <= 1'b0;
            r_last       <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_pease_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_pease_twiddle_sequencer
// Brief  : Scoreboard bench; a formula-level model queues expected beats.
// Rev    : 1.0
// ============================================================================
module tb_fft_pease_twiddle_sequencer;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int DP = 6;
    localparam int LN = 2;
    localparam int L  = 3;
    localparam int B  = N / (2 * LN);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tbl_we = 1'b0;
    logic [2:0]        tbl_addr = '0;
    logic [W-1:0]      tbl_data = '0;
    logic              start = 1'b0;
    logic              inverse = 1'b0;
    logic              busy, tw_val, tw_last_stage, tw_last;
    logic              tw_rdy = 1'b0;
    logic [LN*W-1:0]   tw_real, tw_imag;
    logic [2:0]        tw_stage;

    typedef struct {
        logic [LN*W-1:0] re;
        logic [LN*W-1:0] im;
        int              stage;
        bit              ls;
        bit              last;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        e, held;
    bit           hold_valid = 0;
    logic [W-1:0] mtbl [N];
    int           total = 0;
    int           bad = 0;

    fft_pease_twiddle_sequencer #(
        .BIT_WIDTH(W), .DECIMAL_PT(DP), .SIZE_FFT(N), .LANES(LN)
    ) dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .start(start), .inverse(inverse), .busy(busy),
        .tw_val(tw_val), .tw_rdy(tw_rdy), .tw_real(tw_real), .tw_imag(tw_imag),
        .tw_stage(tw_stage), .tw_last_stage(tw_last_stage), .tw_last(tw_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Twiddle exponent for butterfly b in stage s is b rounded down to a multiple of 2^(L-s-1).
    task automatic push_expected(input bit inv);
        beat_t        x;
        int           b, blk, idx;
        logic [W-1:0] re, im;
        for (int s = 0; s < L; s++) begin
            for (int bt = 0; bt < B; bt++) begin
                x.re = '0;
                x.im = '0;
                for (int k = 0; k < LN; k++) begin
                    b   = bt * LN + k;
                    blk = 2 ** (L - s - 1);
                    idx = (b / blk) * blk;
                    if (s == 0) begin
                        re = W'(64);
                        im = '0;
                    end else begin
                        re = mtbl[idx + N / 4];
                        im = mtbl[idx + N / 2];
                    end
                    if (inv) im = W'(0) - im;
                    x.re[k*W +: W] = re;
                    x.im[k*W +: W] = im;
                end
                x.stage = s;
                x.ls    = (bt == B - 1);
                x.last  = (bt == B - 1) && (s == L - 1);
                exp_q.push_back(x);
            end
        end
    endtask

    // Monitor: each handshake pops one expected beat; stalled beats must hold.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tw_val) begin
                if (hold_valid) begin
                    total++;
                    if (tw_real !== held.re || tw_imag !== held.im || int'(tw_stage) != held.stage
                        || tw_last_stage !== held.ls || tw_last !== held.last) begin
                        bad++;
                        $display("FAIL hold: got re=%h im=%h s=%0d required re=%h im=%h s=%0d",
                                 tw_real, tw_imag, tw_stage, held.re, held.im, held.stage);
                    end
                end
                if (tw_rdy) begin
                    hold_valid = 0;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL beat: unexpected beat re=%h im=%h s=%0d", tw_real, tw_imag, tw_stage);
                    end else begin
                        e = exp_q.pop_front();
                        if (tw_real !== e.re || tw_imag !== e.im || int'(tw_stage) != e.stage
                            || tw_last_stage !== e.ls || tw_last !== e.last) begin
                            bad++;
                            $display("FAIL beat: got re=%h im=%h s=%0d ls=%b l=%b required re=%h im=%h s=%0d ls=%b l=%b",
                                     tw_real, tw_imag, tw_stage, tw_last_stage, tw_last,
                                     e.re, e.im, e.stage, e.ls, e.last);
                        end
                    end
                end else begin
                    held.re = tw_real; held.im = tw_imag; held.stage = int'(tw_stage);
                    held.ls = tw_last_stage; held.last = tw_last;
                    hold_valid = 1;
                end
            end else begin
                hold_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int m, input logic [W-1:0] d);
        tbl_we = 1'b1; tbl_addr = 3'(m); tbl_data = d;
        mtbl[m] = d;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic start_seq(input bit inv, input bit wr, input int wa, input logic [W-1:0] wd);
        start = 1'b1; inverse = inv;
        if (wr) begin
            tbl_we = 1'b1; tbl_addr = 3'(wa); tbl_data = wd;
            mtbl[wa] = wd;
        end
        push_expected(inv);
        tick();
        start = 1'b0; tbl_we = 1'b0;
        inverse = 1'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("val_after_start", 64'(tw_val), 64'd1);
    endtask

    // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random; poke drives ignored writes/starts.
    task automatic drain(input int mode, input bit poke);
        int cyc = 0;
        logic [3:0] pat = 4'b1001;
        while (exp_q.size() != 0 && cyc < 300) begin
            case (mode)
                0:       tw_rdy = 1'b1;
                1:       tw_rdy = pat[cyc % 4];
                default: tw_rdy = 1'($urandom);
            endcase
            if (poke) begin
                tbl_we = 1'($urandom); tbl_addr = 3'($urandom); tbl_data = W'($urandom);
                start = 1'($urandom);
            end
            cyc++;
            tick();
        end
        tbl_we = 1'b0; start = 1'b0;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        chk("busy_after_last", 64'(busy), 64'd0);
        chk("val_after_last", 64'(tw_val), 64'd0);
        tw_rdy = 1'b0;
    endtask

    initial begin
        logic [W-1:0] spec_tbl [N];
        int cyc;
        spec_tbl = '{8'd0, 8'd45, 8'd64, 8'd45, 8'd0, -8'sd45, -8'sd64, -8'sd45};

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_val", 64'(tw_val), 64'd0);
        chk("rst_real", 64'(tw_real), 64'd0);
        chk("rst_imag", 64'(tw_imag), 64'd0);
        chk("rst_stage", 64'(tw_stage), 64'd0);
        chk("rst_last", 64'({tw_last_stage, tw_last}), 64'd0);
        reset = 1'b0;
        tick();

        for (int m = 0; m < N; m++) write_tbl(m, spec_tbl[m]);

        start_seq(0, 0, 0, '0); drain(0, 0);
        start_seq(1, 0, 0, '0); drain(0, 0);
        start_seq(0, 0, 0, '0); drain(1, 0);
        start_seq(1, 0, 0, '0); drain(2, 1);
        start_seq(0, 0, 0, '0); drain(0, 0);

        // Reset while the second beat of stage 1 is presented.
        start_seq(0, 0, 0, '0);
        tw_rdy = 1'b1;
        cyc = 0;
        while (exp_q.size() > 3 && cyc < 50) begin
            cyc++;
            tick();
        end
        chk("pre_reset_stage", 64'(tw_stage), 64'd1);
        tw_rdy = 1'b0; reset = 1'b1;
        tick();
        chk("mid_reset_val", 64'(tw_val), 64'd0);
        chk("mid_reset_busy", 64'(busy), 64'd0);
        chk("mid_reset_real", 64'(tw_real), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        tick();
        start_seq(0, 0, 0, '0); drain(0, 0);

        // Same-cycle write and start: the sequence must see the new entry.
        start_seq(1, 1, 6, W'(8'h80)); drain(0, 0);

        for (int it = 0; it < 10; it++) begin
            for (int m = 0; m < N; m++) write_tbl(m, W'($urandom));
            if (it % 3 == 0) write_tbl(int'($urandom_range(4, 7)), W'(8'h80));
            start_seq(1'($urandom), 0, 0, '0);
            drain(2, 1'($urandom));
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
